// File: rtl/fp_norm_shifter_if.sv
// Handshake and data bundle for the FP32 normalizer.
// The master side feeds beats in and takes results out; the slave side is the normalizer.
interface fp_norm_shifter_if #(
    parameter int MANT_W = 32,
    parameter int EXP_W  = 8
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [MANT_W-1:0] in_mant_i;
    logic [EXP_W-1:0]  in_exp_i;
    logic [4:0]        in_nlz_i;
    logic              in_zero_i;

    logic              out_valid_o;
    logic              out_ready_i;
    logic [MANT_W-1:0] out_mant_o;
    logic [EXP_W-1:0]  out_exp_o;
    logic              out_zero_o;
    logic              out_uflow_o;

    modport master (
        output in_valid_i, in_mant_i, in_exp_i, in_nlz_i, in_zero_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_mant_o, out_exp_o, out_zero_o, out_uflow_o
    );

    modport slave (
        input  in_valid_i, in_mant_i, in_exp_i, in_nlz_i, in_zero_i, out_ready_i,
        output in_ready_o, out_valid_o, out_mant_o, out_exp_o, out_zero_o, out_uflow_o
    );
endinterface

// File: rtl/fp_norm_shifter.sv
// Two-stage normalizer: a nibble-granular coarse shift in stage 1, the
// remaining 0..3 bit shift in stage 2. The exponent is reduced by the shift,
// and when that would drive it to zero or below the shift is limited so the
// result lands in subnormal form with exponent 0.
module fp_norm_shifter #(
    parameter int MANT_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fp_norm_shifter_if.slave  bus
);

    // Handshake
    logic adv1_s;
    logic adv2_s;
    logic xfer_s;

    // Shift decision for the incoming beat
    logic [4:0]        shift_s;
    logic [EXP_W-1:0]  exp_res_s;
    logic              uflow_s;
    logic [EXP_W-1:0]  nlz_ext_s;
    logic [MANT_W-1:0] mant1_s;

    // Stage 1 registers
    logic              v1_r;
    logic [MANT_W-1:0] mant1_r;
    logic [1:0]        fine1_r;
    logic [EXP_W-1:0]  exp1_r;
    logic              zero1_r;
    logic              uflow1_r;

    // Stage 2 registers (drive the outputs directly)
    logic              v2_r;
    logic [MANT_W-1:0] mant2_r;
    logic [EXP_W-1:0]  exp2_r;
    logic              zero2_r;
    logic              uflow2_r;
    logic [MANT_W-1:0] mant2_s;

    assign adv2_s        = ~v2_r | bus.out_ready_i;
    assign adv1_s        = ~v1_r | adv2_s;
    assign xfer_s        = bus.in_valid_i & adv1_s;
    assign bus.in_ready_o = adv1_s;

    assign nlz_ext_s = {{(EXP_W-5){1'b0}}, bus.in_nlz_i};

    // Pick the effective shift and resulting exponent, clamping to subnormal on underflow.
    always_comb begin
        shift_s   = 5'd0;
        exp_res_s = {EXP_W{1'b0}};
        uflow_s   = 1'b0;
        if (bus.in_zero_i) begin
            shift_s   = 5'd0;
            exp_res_s = {EXP_W{1'b0}};
            uflow_s   = 1'b0;
        end else if (bus.in_exp_i > nlz_ext_s) begin
            shift_s   = bus.in_nlz_i;
            exp_res_s = bus.in_exp_i - nlz_ext_s;
            uflow_s   = 1'b0;
        end else if (bus.in_exp_i == {EXP_W{1'b0}}) begin
            shift_s   = 5'd0;
            exp_res_s = {EXP_W{1'b0}};
            uflow_s   = 1'b1;
        end else begin
            // Here 1 <= in_exp_i <= in_nlz_i <= 31, so the low five bits carry the whole value.
            shift_s   = bus.in_exp_i[4:0] - 5'd1;
            exp_res_s = {EXP_W{1'b0}};
            uflow_s   = 1'b1;
        end
    end

    // Coarse shift by the nibble-aligned part of the shift amount; zero inputs force a zero significand.
    always_comb begin
        mant1_s = {MANT_W{1'b0}};
        if (bus.in_zero_i) begin
            mant1_s = {MANT_W{1'b0}};
        end else begin
            mant1_s = bus.in_mant_i << {shift_s[4:2], 2'b00};
        end
    end

    assign mant2_s = mant1_r << fine1_r;

    // Stage 1 register: captures the coarse-shifted beat whenever stage 1 may advance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_r     <= 1'b0;
            mant1_r  <= {MANT_W{1'b0}};
            fine1_r  <= 2'd0;
            exp1_r   <= {EXP_W{1'b0}};
            zero1_r  <= 1'b0;
            uflow1_r <= 1'b0;
        end else if (adv1_s) begin
            v1_r     <= xfer_s;
            mant1_r  <= mant1_s;
            fine1_r  <= shift_s[1:0];
            exp1_r   <= exp_res_s;
            zero1_r  <= bus.in_zero_i;
            uflow1_r <= uflow_s;
        end
    end

    // Stage 2 register: applies the fine shift and holds the result while downstream stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v2_r     <= 1'b0;
            mant2_r  <= {MANT_W{1'b0}};
            exp2_r   <= {EXP_W{1'b0}};
            zero2_r  <= 1'b0;
            uflow2_r <= 1'b0;
        end else if (adv2_s) begin
            v2_r     <= v1_r;
            mant2_r  <= mant2_s;
            exp2_r   <= exp1_r;
            zero2_r  <= zero1_r;
            uflow2_r <= uflow1_r;
        end
    end

    assign bus.out_valid_o = v2_r;
    assign bus.out_mant_o  = mant2_r;
    assign bus.out_exp_o   = exp2_r;
    assign bus.out_zero_o  = zero2_r;
    assign bus.out_uflow_o = uflow2_r;

endmodule

// File: doc/fp_norm_shifter.md
# fp_norm_shifter

Two-stage pipelined normalizer for the FP32 datapath. It consumes a 32-bit unnormalized significand together with the leading-zero count and all-zero flag produced by the FPU's leading-zero counter. It left-shifts the significand so the leading one reaches bit 31, adjusts the exponent, and clamps to IEEE subnormal form when the exponent would underflow. It sits between the add/sub significand datapath and the rounding stage, with a valid/ready handshake on both sides.

## Interface
Parameters:
- MANT_W, 32, significand width; fixed at 32 in this block.
- EXP_W, 8, exponent width.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  block accepts the beat this cycle.
- in_mant_i  input  32  unnormalized significand.
- in_exp_i  input  8  biased exponent before normalization.
- in_nlz_i  input  5  leading-zero count of in_mant_i (0..31).
- in_zero_i  input  1  in_mant_i is all zero; in_nlz_i is don't-care.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts the result.
- out_mant_o  output  32  normalized or subnormal significand.
- out_exp_o  output  8  adjusted biased exponent.
- out_zero_o  output  1  result is exact zero.
- out_uflow_o  output  1  result was clamped to subnormal (exponent 0).

## Operation
- Effective shift s (5 bits), computed from the input beat:
  - in_zero_i=1: s=0.
  - else if in_exp_i > in_nlz_i: s=in_nlz_i, exp_res=in_exp_i-in_nlz_i, uflow=0.
  - else if in_exp_i=0: s=0, exp_res=0, uflow=1.
  - else: s=in_exp_i-1, exp_res=0, uflow=1.
- The comparison is unsigned 8-bit against the zero-extended nlz. The exponent subtraction never wraps because of the guard above.
- Zero path: out_mant=0, out_exp=0, out_zero=1, out_uflow=0, regardless of in_exp_i.
- Stage 1 (coarse, nibble granular): mant1 = in_mant_i << {s[4:2],2'b00}. Registers mant1, s[1:0], exp_res, zero and uflow flags, and v1.
- Stage 2 (fine): mant2 = mant1 << s[1:0]. Registers the outputs and v2 (= out_valid_o).
- Bits shifted out on the left are discarded; zeros fill from the right.
- Handshake, standard stall pipeline:
  - adv2 = ~v2 | out_ready_i.
  - adv1 = ~v1 | adv2.
  - in_ready_o = adv1, combinational; no combinational path from in_valid_i to in_ready_o.
  - Input transfer when in_valid_i & in_ready_o.
  - Stage 2 loads the stage 1 contents when adv2. v2 becomes v1 when adv2.
  - Stage 1 loads the input when adv1. v1 becomes (in_valid_i & in_ready_o) when adv1.
- While out_valid_o=1 and out_ready_i=0, all out_* hold stable and no beat is lost or duplicated.
- Data registers may load on any advance. Only the valid bits are qualified.

## Timing
- Latency: 2 cycles from input transfer to out_valid_o, with no stall.
- Throughput: 1 beat per cycle while out_ready_i=1.
- Reset (rst_i=1 at an edge):
  - v1, v2, and all data registers clear to 0.
  - out_valid_o=0, out_mant_o=0, out_exp_o=0, out_zero_o=0, out_uflow_o=0.
  - in_ready_o=1 from the first cycle after reset.
- Reset mid-operation flushes both in-flight beats without emitting them. An input offered in the reset cycle is not captured.
- Full pipeline (v1=v2=1) with out_ready_i=0 drives in_ready_o=0.
- Simultaneous output handshake and input transfer on a full pipeline: both stages shift, and the new beat enters stage 1 in the same cycle.
- Output data changes only on a cycle where adv2=1.

## Test plan
- Normal shift: mant=0x0000_1234, nlz=19, exp=100 -> after 2 cycles: mant=0x91A0_0000, exp=81, zero=0, uflow=0.
- Subnormal clamp:
  - mant=0x0000_1234, nlz=19, exp=5 -> mant=0x0001_2340, exp=0, uflow=1.
  - Boundary, same mant and nlz: exp=20 -> mant=0x91A0_0000, exp=1, uflow=0.
  - Boundary, same mant and nlz: exp=19 -> mant=0x48D0_0000, exp=0, uflow=1.
- Zero and extremes:
  - zero=1, mant=0, exp=0x7F -> mant=0, exp=0, zero=1, uflow=0.
  - mant=0x0000_0001, nlz=31, exp=200 -> mant=0x8000_0000, exp=169.
  - mant=0x8000_0000, nlz=0, exp=0 -> mant=0x8000_0000, exp=0, uflow=1.
- Backpressure:
  - Stream 5 beats back-to-back, hold out_ready_i=0 for cycles 3-6 -> in_ready_o=0 once both stages fill, and outputs stay stable.
  - All 5 beats emerge in order, each exactly once.
  - Random out_ready_i over 1000 beats matches a reference model.
- Reset mid-stream: assert rst_i with 2 beats in flight -> next cycle out_valid_o=0 and all outputs 0, in_ready_o=1, and no flushed beat appears afterwards.
